seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, pattern length in bits; legal range 2..32.
REQ-002 SHALL have parameter PATTERN, default 4'b1110, target sequence; PATTERN[PAT_LEN-1] is the first bit received.
REQ-003 SHALL have parameter MEALY, default 0; 0 gives a registered (Moore) Dout, 1 gives a combinational (Mealy) Dout.
REQ-004 SHALL have parameter OVERLAP, default 1; 1 lets matches share bits, 0 restarts detection after each match.
REQ-005 SHALL have parameter CNT_W, default 8, width of Hit_cnt.
REQ-006 SHALL have port Clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port En, input, 1 bit: Din is accepted on a rising Clk edge only when En=1.
REQ-009 SHALL have port Din, input, 1 bit: serial data bit.
REQ-010 SHALL have port Cnt_clr, input, 1 bit: synchronous clear of Hit_cnt.
REQ-011 SHALL have port Dout, output, 1 bit: match indication.
REQ-012 SHALL have port Hit_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-013 SHALL keep window W of the last PAT_LEN-1 accepted bits (W[0] newest) and fill count F (0..PAT_LEN-1, saturating); En=0 leaves W and F unchanged.
REQ-014 SHALL define match = En && F==PAT_LEN-1 && {W[PAT_LEN-2:0], Din}==PATTERN, evaluated combinationally each cycle.
REQ-015 SHALL, on an accept edge with match=0, shift Din into W[0] and increment F (saturating at PAT_LEN-1).
REQ-016 SHALL, on an accept edge with match=1 and OVERLAP=1, shift Din in and keep F saturated, so the next match can come as soon as one more bit arrives.
REQ-017 SHALL, on an accept edge with match=1 and OVERLAP=0, set F to 0 so that none of the matched bits are reused.
REQ-018 SHALL, when MEALY=1, drive Dout = match combinationally, so Dout is high in the cycle the last pattern bit is presented.
REQ-019 SHALL, when MEALY=0, register Dout <= match on every edge, so Dout is high for exactly one cycle, one cycle after the last bit is accepted.
REQ-020 SHALL increment Hit_cnt by 1 on every edge where match=1, saturating at 2^CNT_W-1.
REQ-021 SHALL give Cnt_clr priority over a simultaneous increment, so Hit_cnt becomes 0 on that edge.
REQ-022 SHALL make the first possible match land on the PAT_LEN-th accepted bit after reset; accepted bits need not be contiguous in cycles.

Reset
REQ-023 SHALL, on a Clk edge with Reset=1, clear W to 0, F to 0, the Moore Dout register to 0 and Hit_cnt to 0; Reset overrides En and Cnt_clr.
REQ-024 SHALL discard any partial pattern when Reset is asserted mid-stream; a bit presented on the reset edge is not accepted.
REQ-025 SHALL hold Dout at 0 in both modes while F is below PAT_LEN-1, including straight after reset.

Configuration
REQ-026 SHALL gate the hit counter with macro SEQ_DETECT_HIT_CNT_EN: when defined, Hit_cnt behaves per REQ-020/021; when undefined, Hit_cnt is tied to 0, Cnt_clr is ignored and no counter flops exist.

Structure
REQ-027 SHALL place default constants (DEF_PAT_LEN=4, DEF_PATTERN=4'b1110, DEF_CNT_W=8) and the mode constants (MODE_MOORE=0, MODE_MEALY=1) in shared package seq_detect_pkg.
REQ-028 SHALL implement the saturating counter with synchronous clear as sub-module seq_hit_counter (parameter CNT_W; ports Clk, Reset, inc, clr, cnt).

Verification
REQ-029 SHALL cover defaults (1110, Moore, overlap) with En=1, Din 1,1,1,1,0 -> Dout high only in the cycle after the 5th bit; Hit_cnt=1.
REQ-030 SHALL cover MEALY=1, same stream -> Dout high in the same cycle the 5th bit (0) is presented; low in all other cycles.
REQ-031 SHALL cover PAT_LEN=4, PATTERN=1010, stream 10101010 -> OVERLAP=1 gives matches on bits 4, 6 and 8 (Hit_cnt=3); OVERLAP=0 gives matches on bits 4 and 8 (Hit_cnt=2).
REQ-032 SHALL cover defaults with stream 1,1,1,0 and En=0 for 3 cycles before the final 0 -> exactly one match; Dout stays low while En=0.
REQ-033 SHALL cover defaults with stream 1,1,1, then Reset for one cycle, then 0 -> no match; then 1,1,1,0 -> one match.
REQ-034 SHALL cover CNT_W=2 with 5 matches -> Hit_cnt saturates at 3; Cnt_clr asserted on a match edge -> Hit_cnt=0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared defaults and output-mode constants for seq_detect_param and seq_hit_counter.
package seq_detect_pkg;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam logic [31:0] DEF_PATTERN = 32'b1110;
  localparam int unsigned DEF_CNT_W   = 8;

  localparam int unsigned MODE_MOORE  = 0;
  localparam int unsigned MODE_MEALY  = 1;

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating match counter with synchronous clear; clear wins over a same-edge increment.
module seq_hit_counter
  import seq_detect_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: window of the last PAT_LEN-1 accepted bits plus a fill count.
// The hit counter exists only when SEQ_DETECT_HIT_CNT_EN is defined; otherwise Hit_cnt is 0.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_LEN = DEF_PAT_LEN,
  parameter logic [31:0] PATTERN = DEF_PATTERN,
  parameter int unsigned MEALY   = MODE_MOORE,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Din,
  input  logic             Cnt_clr,
  output logic             Dout,
  output logic [CNT_W-1:0] Hit_cnt
);

  localparam int unsigned WW = PAT_LEN - 1;
  localparam int unsigned FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] F_FULL = FW'(PAT_LEN - 1);

  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $error("seq_detect_param: PAT_LEN must be in 2..32");
  end
  if (MEALY != MODE_MOORE && MEALY != MODE_MEALY) begin : g_bad_mode
    $error("seq_detect_param: MEALY must be 0 or 1");
  end

  logic [WW-1:0] win_q, win_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          match;

  assign match = En && (fill_q == F_FULL) && ({win_q, Din} == PATTERN[PAT_LEN-1:0]);

  // Truncating cast drops the oldest bit, which also covers PAT_LEN=2 (1-bit window).
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (En) begin
      win_d = WW'({win_q, Din});
      if (match && (OVERLAP == 0)) begin
        fill_d = '0;
      end else if (fill_q != F_FULL) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

  if (MEALY == MODE_MEALY) begin : g_mealy
    assign Dout = match;
  end else begin : g_moore
    logic dout_q;
    always_ff @(posedge Clk) begin
      if (Reset) begin
        dout_q <= 1'b0;
      end else begin
        dout_q <= match;
      end
    end
    assign Dout = dout_q;
  end

`ifdef SEQ_DETECT_HIT_CNT_EN
  seq_hit_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .Clk  (Clk),
    .Reset(Reset),
    .inc  (match),
    .clr  (Cnt_clr),
    .cnt  (Hit_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = Cnt_clr;
  assign Hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: five detector configurations share one input stream and are checked per bit.
module tb_seq_detect_param;

  logic Clk = 1'b0;
  logic Reset, En, Din, Cnt_clr;
  logic d_moore, d_mealy, d_ov, d_nov, d_sat;
  logic [7:0] h_moore, h_mealy, h_ov, h_nov;
  logic [1:0] h_sat;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 Clk = ~Clk;

  seq_detect_param u_moore (
    .Clk(Clk), .Reset(Reset), .En(En), .Din(Din), .Cnt_clr(Cnt_clr),
    .Dout(d_moore), .Hit_cnt(h_moore)
  );

  seq_detect_param #(.MEALY(1)) u_mealy (
    .Clk(Clk), .Reset(Reset), .En(En), .Din(Din), .Cnt_clr(Cnt_clr),
    .Dout(d_mealy), .Hit_cnt(h_mealy)
  );

  seq_detect_param #(.PAT_LEN(4), .PATTERN(32'b1010), .OVERLAP(1)) u_ov (
    .Clk(Clk), .Reset(Reset), .En(En), .Din(Din), .Cnt_clr(Cnt_clr),
    .Dout(d_ov), .Hit_cnt(h_ov)
  );

  seq_detect_param #(.PAT_LEN(4), .PATTERN(32'b1010), .OVERLAP(0)) u_nov (
    .Clk(Clk), .Reset(Reset), .En(En), .Din(Din), .Cnt_clr(Cnt_clr),
    .Dout(d_nov), .Hit_cnt(h_nov)
  );

  seq_detect_param #(.CNT_W(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .En(En), .Din(Din), .Cnt_clr(Cnt_clr),
    .Dout(d_sat), .Hit_cnt(h_sat)
  );

  // Counter outputs are tied to zero unless the hit counter is built in.
  function automatic logic [31:0] hc(input int unsigned n);
`ifdef SEQ_DETECT_HIT_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic en, input logic d);
    Reset = 1'b1; En = en; Din = d; Cnt_clr = 1'b0;
    @(posedge Clk); #1;
    check("rst_moore_dout", 32'(d_moore), 32'd0);
    check("rst_ov_dout",    32'(d_ov),    32'd0);
    check("rst_moore_hit",  32'(h_moore), 32'd0);
    check("rst_sat_hit",    32'(h_sat),   32'd0);
    check("rst_nov_hit",    32'(h_nov),   32'd0);
    Reset = 1'b0;
  endtask

  // One bit: Mealy output checked before the edge, registered outputs just after it.
  task automatic step(input logic en, input logic d, input logic clr,
                      input logic m1110, input logic mov, input logic mnov);
    Reset = 1'b0; En = en; Din = d; Cnt_clr = clr;
    #1;
    check("mealy_dout", 32'(d_mealy), 32'(m1110));
    @(posedge Clk); #1;
    check("moore_dout", 32'(d_moore), 32'(m1110));
    check("sat_dout",   32'(d_sat),   32'(m1110));
    check("ov_dout",    32'(d_ov),    32'(mov));
    check("nov_dout",   32'(d_nov),   32'(mnov));
  endtask

  initial begin
    logic [4:0] s5;
    logic [7:0] s8;

    Reset = 1'b1; En = 1'b0; Din = 1'b0; Cnt_clr = 1'b0;
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);

    // 1,1,1,1,0 against 1110: only the fifth bit completes the pattern
    s5 = 5'b11110;
    for (int i = 0; i < 5; i++) step(1'b1, s5[4-i], 1'b0, i == 4, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_moore_hit", 32'(h_moore), hc(1));
    check("a_mealy_hit", 32'(h_mealy), hc(1));

    // 10101010 against 1010: overlap hits bits 4,6,8; restart hits bits 4,8
    do_reset(1'b0, 1'b0);
    s8 = 8'b10101010;
    for (int i = 0; i < 8; i++)
      step(1'b1, s8[7-i], 1'b0, 1'b0, (i == 3) || (i == 5) || (i == 7), (i == 3) || (i == 7));
    check("c_ov_hit",    32'(h_ov),    hc(3));
    check("c_nov_hit",   32'(h_nov),   hc(2));
    check("c_moore_hit", 32'(h_moore), hc(0));

    // Gap of En=0 with Din=0 presented must not complete 1110
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d_moore_hit", 32'(h_moore), hc(1));

    // Reset mid-pattern discards 1,1,1; the bit on the reset edge is ignored
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("e_moore_hit", 32'(h_moore), hc(1));

    // Five matches saturate the 2-bit counter; clear on a match edge wins
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("f_sat_hit",   32'(h_sat),   hc((k + 1 > 3) ? 3 : k + 1));
      check("f_moore_hit", 32'(h_moore), hc(k + 1));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("f_clr_sat_hit",   32'(h_sat),   hc(0));
    check("f_clr_moore_hit", 32'(h_moore), hc(0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f_after_clr_sat_hit", 32'(h_sat), hc(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
